decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameters SHALL be, one per line:
  IW, 9, instruction width
  DW, 8, data/immediate width
  PW, 3, register address width
REQ-002 Ports SHALL be, one per line:
  clock  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-high reset
  instrValid  in  1  fetch presents an instruction
  instruction  in  IW  [8:6] opcode, [5:3] rd, [2:0] rs/idx
  stall  in  1  downstream not ready; hold outputs
  flush  in  1  discard output, insert bubble
  instrReady  out  1  instruction accepted this edge when high with instrValid
  outValid  out  1  decoded outputs valid
  readRegister1  out  PW  rd field (dest/first source)
  readRegister2  out  PW  rs field
  immediate  out  1  second operand is ltValue
  ltValue  out  DW  LUT immediate
  regWrite, memRead, memWrite, branch  out  1 each  control
  aluOp  out  3  ALU operation
  done  out  1  HALT retired
REQ-003 There SHALL be one clock and one reset; reset is asynchronous and active-high.

Function
REQ-004 Opcodes SHALL be: 0 ADD, 1 SUB, 2 AND (rd=rd op rs); 3 SHL (rd=rd<<LUT[idx]); 4 LDI (rd=LUT[idx]); 5 LW (rd=mem[rs]); 6 SW (mem[rs]=rd); 7 BEQZ (branch by LUT[idx] if rd==0), except instruction 9'b111_xxx_111 = HALT.
REQ-005 LUT[0..7] SHALL be 0,1,2,4,8,16,64,255; ltValue=LUT[idx] for SHL, LDI, BEQZ, else 0.
REQ-006 immediate SHALL be 1 for SHL, LDI, BEQZ only; regWrite 1 for ops 0-5; memRead only LW; memWrite only SW; branch only BEQZ; aluOp = opcode for ops 0-3, 0 otherwise.
REQ-007 Latency SHALL be one cycle: instruction accepted at edge N appears on outputs with outValid=1 after edge N.
REQ-008 instrReady SHALL equal state==RUN && !stall && !flush && !hazard (combinational).
REQ-009 hazard SHALL be 1 when outValid && memRead && the incoming instruction reads register readRegister1 (sources: rd for ops 0-3, 6, 7; rs for ops 0-2, 5, 6; LDI reads none).
REQ-010 On hazard (not stalled) the next edge SHALL load a bubble; the held instruction is accepted the following cycle.
REQ-011 A bubble SHALL be outValid=0 with regWrite, memRead, memWrite, branch, immediate = 0.
REQ-012 stall=1 SHALL hold all outputs unchanged; flush SHALL override stall and load a bubble.
REQ-013 States SHALL be RUN and HALTED; accepted HALT loads a bubble and enters HALTED; done=1 from that edge until reset; instrReady=0 in HALTED; flush in HALTED keeps the bubble.
REQ-014 instrValid=0 in RUN (not stalled) SHALL load a bubble.

Reset
REQ-015 reset=1 SHALL immediately force state RUN, all outputs 0 (bubble), done=0, regardless of clock.
REQ-016 Reset asserted mid-stall, mid-hazard or in HALTED SHALL yield the same state; first accept possible on the first edge after deassertion.

Structure
REQ-017 Package decode_pkg SHALL hold the opcode enum, aluOp enum, HALT encoding, LUT constant and the state enum.
REQ-018 One combinational sub-module, immediate_lut (idx in, DW value out), SHALL implement REQ-005.

Verification
REQ-019 After reset: instruction 9'b000_001_010 valid -> next cycle outValid=1, readRegister1=1, readRegister2=2, aluOp=0, regWrite=1, immediate=0.
REQ-020 LDI 9'b100_011_111 -> ltValue=255, immediate=1, readRegister1=3, regWrite=1.
REQ-021 LW 9'b101_010_000 then ADD 9'b000_010_001 -> instrReady=0 one cycle, one bubble, ADD on outputs after next edge.
REQ-022 stall=1 for 3 cycles with SUB on outputs -> outputs unchanged, instrReady=0; flush=1 with stall=1 -> bubble next edge.
REQ-023 HALT 9'b111_000_111 -> done=1, outValid=0, instrReady=0 for 10 cycles; reset -> done=0, instrReady=1.
REQ-024 Asynchronous reset pulse between clock edges with outValid=1 -> outputs 0 before next edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types and constants for the decode stage: opcode and ALU encodings,
// the HALT pattern, the immediate lookup table and the stage state.
package decode_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_SHL  = 3'd3,
        OP_LDI  = 3'd4,
        OP_LW   = 3'd5,
        OP_SW   = 3'd6,
        OP_BEQZ = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_SHL = 3'd3
    } alu_op_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    // HALT is BEQZ with idx 7: 9'b111_xxx_111 (rd field is don't-care).
    localparam logic [8:0] HALT_MASK  = 9'b111_000_111;
    localparam logic [8:0] HALT_MATCH = 9'b111_000_111;

    // Immediate table, entry 0 in the least significant byte.
    localparam logic [7:0][7:0] IMM_LUT = {
        8'd255, 8'd64, 8'd16, 8'd8, 8'd4, 8'd2, 8'd1, 8'd0
    };

endpackage

// File: rtl/immediate_lut.sv
// Combinational immediate table: maps the 3-bit idx field to its constant.
module immediate_lut
    import decode_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = 3
) (
    input  logic [PW-1:0] idx,
    output logic [DW-1:0] value
);

    // Pure table lookup, resized to the data width.
    assign value = DW'(IMM_LUT[idx]);

endmodule

// File: rtl/decode_stage.sv
// Single-cycle decode stage with a registered output bundle, load-use hazard
// detection, stall/flush handling and a terminal HALTED state.
module decode_stage
    import decode_pkg::*;
#(
    parameter int IW = 9,
    parameter int DW = 8,
    parameter int PW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          instrValid,
    input  logic [IW-1:0] instruction,
    input  logic          stall,
    input  logic          flush,
    output logic          instrReady,
    output logic          outValid,
    output logic [PW-1:0] readRegister1,
    output logic [PW-1:0] readRegister2,
    output logic          immediate,
    output logic [DW-1:0] ltValue,
    output logic          regWrite,
    output logic          memRead,
    output logic          memWrite,
    output logic          branch,
    output logic [2:0]    aluOp,
    output logic          done
);

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] rs1;
        logic [PW-1:0] rs2;
        logic          imm;
        logic [DW-1:0] lt;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          branch;
        alu_op_e       alu_op;
    } decoded_t;

    localparam decoded_t BUBBLE = '0;

    opcode_e       opcode;
    logic [PW-1:0] rd;
    logic [PW-1:0] rs;
    logic [DW-1:0] lut_value;
    logic          is_halt;
    logic          reads_rd;
    logic          reads_rs;
    logic          hazard;
    decoded_t      dec;
    decoded_t      out_q, out_d;
    state_e        state_q, state_d;

    assign opcode  = opcode_e'(instruction[IW-1 -: 3]);
    assign rd      = instruction[2*PW-1 -: PW];
    assign rs      = instruction[PW-1:0];
    assign is_halt = (instruction & HALT_MASK) == HALT_MATCH;

    immediate_lut #(.DW(DW), .PW(PW)) u_lut (
        .idx   (rs),
        .value (lut_value)
    );

    // Field decode of the incoming instruction and its source-register usage.
    always_comb begin
        // NOTE: every signal gets a default first so no latch can be inferred.
        dec        = BUBBLE;
        dec.valid  = 1'b1;
        dec.rs1    = rd;
        dec.rs2    = rs;
        reads_rd   = 1'b0;
        reads_rs   = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = alu_op_e'(opcode);
                reads_rd      = 1'b1;
                reads_rs      = 1'b1;
            end
            OP_SHL: begin
                dec.reg_write = 1'b1;
                dec.imm       = 1'b1;
                dec.lt        = lut_value;
                dec.alu_op    = ALU_SHL;
                reads_rd      = 1'b1;
            end
            OP_LDI: begin
                dec.reg_write = 1'b1;
                dec.imm       = 1'b1;
                dec.lt        = lut_value;
            end
            OP_LW: begin
                dec.reg_write = 1'b1;
                dec.mem_read  = 1'b1;
                reads_rs      = 1'b1;
            end
            OP_SW: begin
                dec.mem_write = 1'b1;
                reads_rd      = 1'b1;
                reads_rs      = 1'b1;
            end
            OP_BEQZ: begin
                dec.branch    = 1'b1;
                dec.imm       = 1'b1;
                dec.lt        = lut_value;
                reads_rd      = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load now on the outputs targets a register the
    // incoming instruction reads, so one bubble must separate them.
    assign hazard = out_q.valid && out_q.mem_read &&
                    ((reads_rd && (rd == out_q.rs1)) ||
                     (reads_rs && (rs == out_q.rs1)));

    assign instrReady = (state_q == ST_RUN) && !stall && !flush && !hazard;

    // Next-state and next-output selection: flush beats stall, stall holds.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) begin
                    out_d = BUBBLE;
                end else if (!stall) begin
                    if (instrValid && !hazard) begin
                        if (is_halt) begin
                            out_d   = BUBBLE;
                            state_d = ST_HALTED;
                        end else begin
                            out_d = dec;
                        end
                    end else begin
                        out_d = BUBBLE;
                    end
                end
            end
            ST_HALTED: begin
                out_d = BUBBLE;
            end
        endcase
    end

    // State and output registers; reset clears to RUN with a bubble.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            out_q   <= BUBBLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    assign outValid      = out_q.valid;
    assign readRegister1 = out_q.rs1;
    assign readRegister2 = out_q.rs2;
    assign immediate     = out_q.imm;
    assign ltValue       = out_q.lt;
    assign regWrite      = out_q.reg_write;
    assign memRead       = out_q.mem_read;
    assign memWrite      = out_q.mem_write;
    assign branch        = out_q.branch;
    assign aluOp         = out_q.alu_op;
    assign done          = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with an expected-output scoreboard.
module tb_decode_stage;

    logic       clock;
    logic       reset;
    logic       instrValid;
    logic [8:0] instruction;
    logic       stall;
    logic       flush;
    logic       instrReady;
    logic       outValid;
    logic [2:0] readRegister1;
    logic [2:0] readRegister2;
    logic       immediate;
    logic [7:0] ltValue;
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       branch;
    logic [2:0] aluOp;
    logic       done;

    typedef struct packed {
        logic       valid;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic       imm;
        logic [7:0] lt;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
        logic [2:0] alu;
        logic       done;
    } exp_t;

    exp_t scoreboard[$];
    int   n_vec = 0;
    int   n_err = 0;

    decode_stage dut (
        .clock         (clock),
        .reset         (reset),
        .instrValid    (instrValid),
        .instruction   (instruction),
        .stall         (stall),
        .flush         (flush),
        .instrReady    (instrReady),
        .outValid      (outValid),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .immediate     (immediate),
        .ltValue       (ltValue),
        .regWrite      (regWrite),
        .memRead       (memRead),
        .memWrite      (memWrite),
        .branch        (branch),
        .aluOp         (aluOp),
        .done          (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic exp_t sample();
        exp_t s;
        s = {outValid, readRegister1, readRegister2, immediate, ltValue,
             regWrite, memRead, memWrite, branch, aluOp, done};
        return s;
    endfunction

    function automatic exp_t bub(input logic d);
        exp_t e;
        e      = '0;
        e.done = d;
        return e;
    endfunction

    function automatic logic [7:0] lut(input logic [2:0] idx);
        case (idx)
            3'd0: return 8'd0;
            3'd1: return 8'd1;
            3'd2: return 8'd2;
            3'd3: return 8'd4;
            3'd4: return 8'd8;
            3'd5: return 8'd16;
            3'd6: return 8'd64;
            default: return 8'd255;
        endcase
    endfunction

    // Reference decode from the opcode table.
    function automatic exp_t model(input logic [8:0] ins);
        exp_t       e;
        logic [2:0] op;
        op    = ins[8:6];
        e     = '0;
        e.valid = 1'b1;
        e.rr1 = ins[5:3];
        e.rr2 = ins[2:0];
        case (op)
            3'd0, 3'd1, 3'd2: begin e.rw = 1'b1; e.alu = op; end
            3'd3: begin e.rw = 1'b1; e.imm = 1'b1; e.lt = lut(ins[2:0]); e.alu = 3'd3; end
            3'd4: begin e.rw = 1'b1; e.imm = 1'b1; e.lt = lut(ins[2:0]); end
            3'd5: begin e.rw = 1'b1; e.mr = 1'b1; end
            3'd6: begin e.mw = 1'b1; end
            default: begin e.br = 1'b1; e.imm = 1'b1; e.lt = lut(ins[2:0]); end
        endcase
        return e;
    endfunction

    // Drive one cycle now, check ready, then compare outputs after the edge.
    task automatic apply(input string tag, input logic v, input logic [8:0] ins,
                         input logic st, input logic fl, input logic exp_rdy, input exp_t nxt);
        exp_t want;
        instrValid  = v;
        instruction = ins;
        stall       = st;
        flush       = fl;
        #1;
        check({tag, ".ready"}, 32'(instrReady), 32'(exp_rdy));
        scoreboard.push_back(nxt);
        @(posedge clock);
        #1;
        want = scoreboard.pop_front();
        check({tag, ".out"}, 32'(sample()), 32'(want));
    endtask

    task automatic step(input string tag, input logic v, input logic [8:0] ins,
                        input logic st, input logic fl, input logic exp_rdy, input exp_t nxt);
        @(negedge clock);
        apply(tag, v, ins, st, fl, exp_rdy, nxt);
    endtask

    localparam logic [8:0] I_ADD12  = 9'b000_001_010;
    localparam logic [8:0] I_LDI    = 9'b100_011_111;
    localparam logic [8:0] I_LW20   = 9'b101_010_000;
    localparam logic [8:0] I_ADD21  = 9'b000_010_001;
    localparam logic [8:0] I_SUB    = 9'b001_100_101;
    localparam logic [8:0] I_AND    = 9'b010_111_000;
    localparam logic [8:0] I_SHL    = 9'b011_001_101;
    localparam logic [8:0] I_BEQZ   = 9'b111_000_011;
    localparam logic [8:0] I_SW     = 9'b110_101_110;
    localparam logic [8:0] I_LW31   = 9'b101_011_001;
    localparam logic [8:0] I_LDI30  = 9'b100_011_000;
    localparam logic [8:0] I_LW40   = 9'b101_100_000;
    localparam logic [8:0] I_SW04   = 9'b110_000_100;
    localparam logic [8:0] I_HALT   = 9'b111_000_111;

    initial begin
        reset       = 1'b1;
        instrValid  = 1'b0;
        instruction = '0;
        stall       = 1'b0;
        flush       = 1'b0;
        #1;
        check("reset.out", 32'(sample()), 32'(bub(1'b0)));
        check("reset.ready", 32'(instrReady), 32'd1);
        @(negedge clock);
        reset = 1'b0;

        // Basic decode of each operation class.
        step("add",  1'b1, I_ADD12, 1'b0, 1'b0, 1'b1, model(I_ADD12));
        step("ldi",  1'b1, I_LDI,   1'b0, 1'b0, 1'b1, model(I_LDI));

        // Load-use hazard on rd: one bubble, then the ADD.
        step("lw",       1'b1, I_LW20,  1'b0, 1'b0, 1'b1, model(I_LW20));
        step("hz.bub",   1'b1, I_ADD21, 1'b0, 1'b0, 1'b0, bub(1'b0));
        step("hz.add",   1'b1, I_ADD21, 1'b0, 1'b0, 1'b1, model(I_ADD21));

        // Stall holds, flush overrides stall.
        step("sub",      1'b1, I_SUB, 1'b0, 1'b0, 1'b1, model(I_SUB));
        for (int i = 0; i < 3; i++)
            step("stall", 1'b1, I_AND, 1'b1, 1'b0, 1'b0, model(I_SUB));
        step("flush",    1'b1, I_AND, 1'b1, 1'b1, 1'b0, bub(1'b0));
        step("idle",     1'b0, I_AND, 1'b0, 1'b0, 1'b1, bub(1'b0));

        step("shl",      1'b1, I_SHL,  1'b0, 1'b0, 1'b1, model(I_SHL));
        step("beqz",     1'b1, I_BEQZ, 1'b0, 1'b0, 1'b1, model(I_BEQZ));
        step("sw",       1'b1, I_SW,   1'b0, 1'b0, 1'b1, model(I_SW));

        // LDI reads no register, so no hazard behind a matching load.
        step("lw3",      1'b1, I_LW31,  1'b0, 1'b0, 1'b1, model(I_LW31));
        step("ldi.nohz", 1'b1, I_LDI30, 1'b0, 1'b0, 1'b1, model(I_LDI30));

        // Hazard through the rs field.
        step("lw4",      1'b1, I_LW40, 1'b0, 1'b0, 1'b1, model(I_LW40));
        step("hzrs.bub", 1'b1, I_SW04, 1'b0, 1'b0, 1'b0, bub(1'b0));
        step("hzrs.sw",  1'b1, I_SW04, 1'b0, 1'b0, 1'b1, model(I_SW04));
        step("shl2",     1'b1, I_SHL,  1'b0, 1'b0, 1'b1, model(I_SHL));

        // Asynchronous reset pulse between edges with a valid output.
        #2;
        reset = 1'b1;
        #1;
        check("areset.out", 32'(sample()), 32'(bub(1'b0)));
        #1;
        reset = 1'b0;

        // HALT: bubble, done stays high, nothing accepted, flush keeps bubble.
        step("halt", 1'b1, I_HALT, 1'b0, 1'b0, 1'b1, bub(1'b1));
        for (int i = 0; i < 10; i++)
            step("halted", 1'b1, I_ADD12, 1'b0, (i == 4), 1'b0, bub(1'b1));

        // Reset out of HALTED; first accept on the first edge after release.
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("halt.reset.out", 32'(sample()), 32'(bub(1'b0)));
        #1;
        reset = 1'b0;
        apply("post.add", 1'b1, I_ADD12, 1'b0, 1'b0, 1'b1, model(I_ADD12));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
